// File: rtl/ara_inval_broadcaster.sv
// Fans vector-unit AXI write bursts out as per-line L1 invalidations to scalar harts.
// Requests queue as (first,last) line pairs; the FSM then walks each line and broadcasts it to the enabled harts.

module ara_inval_lane (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  input  logic bcast_i,
  input  logic ready_i,
  output logic pend_o,
  output logic valid_o
);
  logic pend_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                pend_q <= 1'b0;
    else if (load_i)            pend_q <= en_i;
    else if (bcast_i && ready_i) pend_q <= 1'b0;
  end

  assign pend_o  = pend_q;
  assign valid_o = bcast_i & pend_q;
endmodule

module ara_inval_broadcaster #(
  parameter int unsigned NrHarts   = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned LineBytes = 16,
  parameter int unsigned Depth     = 4,
  parameter int unsigned Coalesce  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [7:0]           wr_len_i,
  input  logic [2:0]           wr_size_i,
  input  logic [NrHarts-1:0]   en_i,
  output logic [NrHarts-1:0]   inval_valid_o,
  input  logic [NrHarts-1:0]   inval_ready_i,
  output logic [AddrWidth-1:0] inval_addr_o,
  output logic                 busy_o
);
  localparam int unsigned Off   = $clog2(LineBytes);
  localparam int unsigned LineW = AddrWidth - Off;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(Depth);

  typedef struct packed {
    logic [LineW-1:0] first;
    logic [LineW-1:0] last;
  } req_t;

  typedef enum logic [1:0] {Idle, Bcast, Next} state_e;

  state_e state_q, state_d;

  req_t            mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   cnt_q;
  req_t            push_req, head;
  logic            full, empty, push, pop;

  logic [15:0]          nbytes;
  logic [AddrWidth-1:0] end_addr;

  logic [LineW-1:0]   cur_q, end_q, last_q;
  logic               last_vld_q;
  logic [NrHarts-1:0] pend;
  logic               load, bcast, adv, record, skip, at_end, pend_clr;

  // Burst byte count tops out at 256 beats * 128 B, so 16 bits suffice.
  assign nbytes   = (16'(wr_len_i) + 16'd1) << wr_size_i;
  assign end_addr = wr_addr_i + AddrWidth'(nbytes) - AddrWidth'(1);

  assign push_req.first = LineW'(wr_addr_i >> Off);
  assign push_req.last  = LineW'(end_addr >> Off);

  assign full       = (cnt_q == DepthC);
  assign empty      = (cnt_q == '0);
  assign wr_ready_o = rst_ni & ~full;
  assign push       = wr_valid_i & wr_ready_o;
  assign head       = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_req;
  end

  assign at_end   = (cur_q == end_q);
  assign skip     = (en_i == '0) ||
                    ((Coalesce != 0) && last_vld_q && (cur_q == last_q));
  assign pend_clr = ((pend & ~inval_ready_i) == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:    if (!empty) state_d = Next;
      Next:    if (!skip) state_d = Bcast;
               else if (at_end) state_d = Idle;
      Bcast:   if (pend_clr) state_d = at_end ? Idle : Next;
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    load   = 1'b0;
    bcast  = 1'b0;
    adv    = 1'b0;
    record = 1'b0;
    case (state_q)
      Idle:  pop = ~empty;
      Next: begin
        load = 1'b1;
        adv  = skip & ~at_end;
      end
      Bcast: begin
        bcast  = rst_ni;
        record = pend_clr;
        adv    = pend_clr & ~at_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cur_q      <= '0;
      end_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      if (pop) begin
        cur_q <= head.first;
        end_q <= head.last;
      end else if (adv) begin
        cur_q <= cur_q + LineW'(1);
      end
      if (record) begin
        last_q     <= cur_q;
        last_vld_q <= 1'b1;
      end
    end
  end

  // en_i is latched once per line on entry to Bcast, so later en_i changes only hit later lines.
  for (genvar h = 0; h < NrHarts; h++) begin : g_lane
    ara_inval_lane u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load),
      .en_i    (en_i[h]),
      .bcast_i (bcast),
      .ready_i (inval_ready_i[h]),
      .pend_o  (pend[h]),
      .valid_o (inval_valid_o[h])
    );
  end

  assign inval_addr_o = bcast ? {cur_q, {Off{1'b0}}} : '0;
  assign busy_o       = rst_ni & (~empty | (state_q != Idle));
endmodule

// File: tb/tb_ara_inval_broadcaster.sv
// Directed bench for ara_inval_broadcaster: queue-based reference model checked every cycle
// plus hand-computed expectations for the listed scenarios.
module tb_ara_inval_broadcaster;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [63:0] wr_addr = '0;
  logic [7:0]  wr_len = '0;
  logic [2:0]  wr_size = '0;
  logic [1:0]  en = 2'b11;
  logic [1:0]  rdy = 2'b11;

  logic        wr_ready, busy, nc_wr_ready, nc_busy;
  logic [1:0]  valid, nc_valid;
  logic [63:0] addr, nc_addr;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ara_inval_broadcaster #(.NrHarts(2), .AddrWidth(64), .LineBytes(16), .Depth(DEPTH), .Coalesce(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr), .wr_len_i(wr_len), .wr_size_i(wr_size), .en_i(en),
    .inval_valid_o(valid), .inval_ready_i(rdy), .inval_addr_o(addr), .busy_o(busy));

  ara_inval_broadcaster #(.NrHarts(2), .AddrWidth(64), .LineBytes(16), .Depth(DEPTH), .Coalesce(0)) u_dut_nc (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(nc_wr_ready),
    .wr_addr_i(wr_addr), .wr_len_i(wr_len), .wr_size_i(wr_size), .en_i(en),
    .inval_valid_o(nc_valid), .inval_ready_i(rdy), .inval_addr_o(nc_addr), .busy_o(nc_busy));

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: list of outstanding line ranges and the line currently being worked.
  typedef struct { logic [63:0] f; logic [63:0] l; } mreq_t;
  mreq_t       mq[$];
  int          m_ph = 0;          // 0 idle, 1 choose line, 2 broadcasting
  logic [63:0] m_cur = '0, m_end = '0, m_last = '0;
  bit          m_lastv = 1'b0;
  logic [1:0]  m_pend = '0;

  always @(posedge clk) begin
    bit    acc;
    mreq_t r;
    if (!rst_n) begin
      mq.delete();
      m_ph = 0; m_pend = '0; m_lastv = 1'b0; m_last = '0; m_cur = '0; m_end = '0;
    end else begin
      acc = wr_valid && (mq.size() < DEPTH);
      if (m_ph == 0) begin
        if (mq.size() > 0) begin
          r = mq.pop_front();
          m_cur = r.f; m_end = r.l; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (en == 2'b00 || (m_lastv && m_cur == m_last)) begin
          if (m_cur == m_end) m_ph = 0;
          else m_cur = m_cur + 1;
        end else begin
          m_pend = en; m_ph = 2;
        end
      end else begin
        m_pend = m_pend & ~rdy;
        if (m_pend == 2'b00) begin
          m_last = m_cur; m_lastv = 1'b1;
          if (m_cur == m_end) m_ph = 0;
          else begin m_cur = m_cur + 1; m_ph = 1; end
        end
      end
      if (acc) begin
        r.f = wr_addr >> 4;
        r.l = (wr_addr + ((64'(wr_len) + 64'd1) << wr_size) - 64'd1) >> 4;
        mq.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_wr_ready", {63'd0, wr_ready}, {63'd0, rst_n && (mq.size() < DEPTH)});
      cmp("model_valid", {62'd0, valid}, (rst_n && m_ph == 2) ? {62'd0, m_pend} : 64'd0);
      cmp("model_addr", addr, (rst_n && m_ph == 2) ? (m_cur << 4) : 64'd0);
      cmp("model_busy", {63'd0, busy}, {63'd0, rst_n && (mq.size() > 0 || m_ph != 0)});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    at_neg();
    cmp("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    cmp("rst_busy", {63'd0, busy}, 64'd0);
    cmp("rst_valid", {62'd0, valid}, 64'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_len = l; wr_size = s;
    while (!wr_ready && n < 50) begin step(); n++; end
    if (!wr_ready) cmp("send_timeout", 64'd0, 64'd1);
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ev[0:8];
    logic [63:0] ea[0:8];
    logic        eb[0:3];
    int acc, n, n1, n0;

    // Reset with a write held valid; it must be ignored.
    wr_valid = 1'b1; wr_addr = 64'h5000;
    @(posedge clk); chk_en = 1'b1; #1;
    step(); step();
    at_neg();
    cmp("rst_ignore_ready", {63'd0, wr_ready}, 64'd0);
    cmp("rst_ignore_busy", {63'd0, busy}, 64'd0);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    step(); step();
    at_neg();
    cmp("post_rst_busy", {63'd0, busy}, 64'd0);

    // Single line, exact k+3 latency.
    en = 2'b11; rdy = 2'b11;
    send(64'h1000, 8'd0, 3'd3);
    ev = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    ea = '{0, 0, 64'h1000, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      at_neg();
      cmp("one_valid", {62'd0, valid}, {62'd0, ev[i]});
      cmp("one_addr", addr, ea[i]);
      step();
    end
    cmp("one_busy_fall", {63'd0, busy}, 64'd0);

    // Burst straddling two lines.
    do_reset();
    send(64'h1008, 8'd1, 3'd3);
    ev = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    ea = '{0, 0, 64'h1000, 0, 64'h1010, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      at_neg();
      cmp("two_valid", {62'd0, valid}, {62'd0, ev[i]});
      cmp("two_addr", addr, ea[i]);
      step();
    end
    cmp("two_busy_fall", {63'd0, busy}, 64'd0);

    // Same burst, hart1 ready late by three cycles.
    do_reset();
    rdy = 2'b01;
    send(64'h1008, 8'd1, 3'd3);
    ev = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00};
    ea = '{0, 0, 64'h1000, 64'h1000, 64'h1000, 64'h1000, 0, 64'h1010, 0};
    for (int i = 0; i < 9; i++) begin
      at_neg();
      cmp("slow_valid", {62'd0, valid}, {62'd0, ev[i]});
      cmp("slow_addr", addr, ea[i]);
      rdy = (i >= 5) ? 2'b11 : 2'b01;
      step();
    end

    // Backpressure: Depth+1 accepted while harts stall.
    do_reset();
    rdy = 2'b00;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 64'h4000 + 64'(16 * acc); wr_len = 8'd0; wr_size = 3'd3;
      if (wr_ready) acc++;
      step();
    end
    wr_valid = 1'b0;
    cmp("full_accept_count", 64'(acc), 64'd5);
    at_neg();
    cmp("full_ready_low", {63'd0, wr_ready}, 64'd0);
    step(); step();
    at_neg();
    cmp("full_ready_still_low", {63'd0, wr_ready}, 64'd0);
    rdy = 2'b11;
    n = 0;
    step();
    while (busy && n < 200) begin step(); n++; end
    cmp("full_drain", {63'd0, busy}, 64'd0);

    // Duplicate line writes: coalesced vs not.
    do_reset();
    send(64'h2000, 8'd0, 3'd3);
    send(64'h2000, 8'd0, 3'd3);
    n1 = 0; n0 = 0;
    for (int i = 0; i < 20; i++) begin
      at_neg();
      if (valid != 2'b00) n1++;
      if (nc_valid != 2'b00) n0++;
      step();
    end
    cmp("coalesce_on_count", 64'(n1), 64'd1);
    cmp("coalesce_off_count", 64'(n0), 64'd2);

    // All harts disabled: lines skipped silently.
    do_reset();
    en = 2'b00;
    send(64'h3000, 8'd3, 3'd3);
    eb = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      at_neg();
      cmp("noen_valid", {62'd0, valid}, 64'd0);
      cmp("noen_busy", {63'd0, busy}, {63'd0, eb[i]});
      step();
    end

    // Reset in the middle of a stalled broadcast.
    do_reset();
    en = 2'b11; rdy = 2'b01;
    send(64'h1008, 8'd1, 3'd3);
    step(); step();
    at_neg();
    cmp("midrst_pre_valid", {62'd0, valid}, 64'd3);
    step();
    rst_n = 1'b0;
    at_neg();
    cmp("midrst_valid", {62'd0, valid}, 64'd0);
    cmp("midrst_addr", addr, 64'd0);
    cmp("midrst_busy", {63'd0, busy}, 64'd0);
    cmp("midrst_ready", {63'd0, wr_ready}, 64'd0);
    step(); step();
    rst_n = 1'b1; rdy = 2'b11;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      at_neg();
      if (valid != 2'b00) n++;
    end
    cmp("midrst_no_valids", 64'(n), 64'd0);
    cmp("midrst_busy_after", {63'd0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
